// File: rtl/serial_adder_ctrl_pkg.sv
// Shared state encoding and sizing helpers for the bit-serial adder sequencer.
package serial_adder_ctrl_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Bit-counter width; a 1-bit operand still needs a 1-bit counter.
   function automatic int cnt_width(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/full_adder_cell.sv
// Combinational 1-bit full adder built from two half adders.
module full_adder_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   logic s0;
   logic c0;
   logic c1;

   half_adder u_ha0 (
      .a    (a),
      .b    (b),
      .sum  (s0),
      .cout (c0)
   );

   half_adder u_ha1 (
      .a    (s0),
      .b    (cin),
      .sum  (sum),
      .cout (c1)
   );

   assign cout = c0 | c1;

endmodule

// File: rtl/half_adder.sv
// One-bit half adder: the primitive reused by the serial full-adder cell.
module half_adder (
   input  logic a,
   input  logic b,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b;
   assign cout = a & b;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: sequences one full-adder cell over WIDTH cycles, LSB first.
//   state  | meaning
//   IDLE   | waiting for start; last result held on sum/carry_out
//   RUN    | one operand bit pair added per cycle
//   DONE   | one-cycle completion pulse; start here chains straight into RUN
module serial_adder_ctrl
   import serial_adder_ctrl_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out
);

   localparam int CW = cnt_width(WIDTH);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sa_q, sa_d;
   logic [WIDTH-1:0] sb_q, sb_d;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             co_q, co_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic             fa_sum;
   logic             fa_cout;
   logic [WIDTH:0]   sr_cat;
   logic [WIDTH-1:0] sr_shift;
   logic             last_bit;
   logic             accept;

   full_adder_cell u_fa (
      .a    (sa_q[0]),
      .b    (sb_q[0]),
      .cin  (carry_q),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   // New sum bit enters at the MSB; formed by concatenation so WIDTH=1 needs no special case.
   assign sr_cat   = {fa_sum, sr_q};
   assign sr_shift = sr_cat[WIDTH:1];
   assign last_bit = (cnt_q == CW'(WIDTH - 1));
   assign accept   = start && ((state_q == S_IDLE) || (state_q == S_DONE));

   always_comb begin
      state_d = state_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      sr_d    = sr_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      co_d    = co_q;
      cnt_d   = cnt_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (accept) begin
               sa_d    = a;
               sb_d    = b;
               sr_d    = '0;
               carry_d = 1'b0;
               cnt_d   = '0;
               state_d = S_RUN;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            sa_d    = sa_q >> 1;
            sb_d    = sb_q >> 1;
            sr_d    = sr_shift;
            carry_d = fa_cout;
            cnt_d   = cnt_q + CW'(1);
            if (last_bit) begin
               // Result registers update only here, so they never show a partial sum.
               sum_d   = sr_shift;
               co_d    = fa_cout;
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         sa_q    <= '0;
         sb_q    <= '0;
         sr_q    <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         co_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         sr_q    <= sr_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         co_q    <= co_d;
         cnt_q   <= cnt_d;
      end
   end

   assign busy      = (state_q == S_RUN);
   assign done      = (state_q == S_DONE);
   assign sum       = sum_q;
   assign carry_out = co_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed self-checking bench for serial_adder_ctrl at WIDTH=8 and WIDTH=1.
module tb_serial_adder_ctrl;
   import serial_adder_ctrl_pkg::*;

   logic       clk;
   logic       rst;
   logic       start8;
   logic [7:0] a8, b8;
   logic       busy8, done8, co8;
   logic [7:0] sum8;
   logic       start1;
   logic [0:0] a1, b1;
   logic       busy1, done1, co1;
   logic [0:0] sum1;

   int checks;
   int errors;

   serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
      .clk       (clk),
      .rst       (rst),
      .start     (start8),
      .a         (a8),
      .b         (b8),
      .busy      (busy8),
      .done      (done8),
      .sum       (sum8),
      .carry_out (co8)
   );

   serial_adder_ctrl #(.WIDTH(1)) u_dut1 (
      .clk       (clk),
      .rst       (rst),
      .start     (start1),
      .a         (a1),
      .b         (b1),
      .busy      (busy1),
      .done      (done1),
      .sum       (sum1),
      .carry_out (co1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic obs_busy(input bit w1);
      return w1 ? busy1 : busy8;
   endfunction

   function automatic logic obs_done(input bit w1);
      return w1 ? done1 : done8;
   endfunction

   function automatic logic [7:0] obs_sum(input bit w1);
      return w1 ? {7'b0, sum1} : sum8;
   endfunction

   function automatic logic obs_co(input bit w1);
      return w1 ? co1 : co8;
   endfunction

   // Presents operands with start for one edge; returns at the negedge after the capture edge.
   task automatic launch(input bit w1, input logic [7:0] x, input logic [7:0] y);
      @(negedge clk);
      if (w1) begin
         start1 = 1'b1; a1 = x[0:0]; b1 = y[0:0];
      end else begin
         start8 = 1'b1; a8 = x; b8 = y;
      end
      @(posedge clk);
      @(negedge clk);
      start1 = 1'b0;
      start8 = 1'b0;
   endtask

   // Waits for done, checking latency, busy length and result; unless chaining, also the pulse width.
   task automatic finish(input bit w1, input logic [7:0] es, input logic eco,
                         input int elat, input bit chain, input string name);
      int cyc;
      int busy_cnt;
      cyc = 0;
      busy_cnt = 0;
      while (!obs_done(w1) && cyc < 40) begin
         if (obs_busy(w1)) busy_cnt++;
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (cyc !== elat) begin
         errors++;
         $display("FAIL %s latency: got %0d cycles, expected %0d", name, cyc, elat);
      end
      checks++;
      if (busy_cnt !== elat) begin
         errors++;
         $display("FAIL %s busy_len: got %0d, expected %0d", name, busy_cnt, elat);
      end
      checks++;
      if (obs_sum(w1) !== es) begin
         errors++;
         $display("FAIL %s sum: got %h, expected %h", name, obs_sum(w1), es);
      end
      checks++;
      if (obs_co(w1) !== eco) begin
         errors++;
         $display("FAIL %s carry_out: got %b, expected %b", name, obs_co(w1), eco);
      end
      if (!chain) begin
         @(negedge clk);
         checks++;
         if (obs_done(w1) !== 1'b0) begin
            errors++;
            $display("FAIL %s pulse_width: done still %b one cycle later", name, obs_done(w1));
         end
         checks++;
         if (obs_sum(w1) !== es || obs_co(w1) !== eco) begin
            errors++;
            $display("FAIL %s hold: got %b_%h, expected %b_%h", name, obs_co(w1), obs_sum(w1), eco, es);
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      #1;
      checks++;
      if ({busy8, done8, co8, sum8} !== 11'd0) begin
         errors++;
         $display("FAIL reset_w8: got busy=%b done=%b co=%b sum=%h, expected all 0", busy8, done8, co8, sum8);
      end
      checks++;
      if ({busy1, done1, co1, sum1} !== 4'd0) begin
         errors++;
         $display("FAIL reset_w1: got busy=%b done=%b co=%b sum=%b, expected all 0", busy1, done1, co1, sum1);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_carry_overflow;
      launch(1'b0, 8'hFF, 8'h01);
      finish(1'b0, 8'h00, 1'b1, 8, 1'b0, "ff_plus_01");
   endtask

   task automatic test_patterns;
      launch(1'b0, 8'hA5, 8'h5A);
      finish(1'b0, 8'hFF, 1'b0, 8, 1'b0, "a5_plus_5a");
      launch(1'b0, 8'h00, 8'h00);
      finish(1'b0, 8'h00, 1'b0, 8, 1'b0, "zero_plus_zero");
   endtask

   task automatic test_start_ignored;
      launch(1'b0, 8'h12, 8'h34);
      start8 = 1'b1;
      a8 = 8'h11;
      b8 = 8'h11;
      repeat (4) @(negedge clk);
      start8 = 1'b0;
      finish(1'b0, 8'h46, 1'b0, 4, 1'b0, "start_while_busy");
      repeat (3) begin
         @(negedge clk);
         checks++;
         if (done8 !== 1'b0 || busy8 !== 1'b0) begin
            errors++;
            $display("FAIL extra_op: got done=%b busy=%b, expected 0 0", done8, busy8);
         end
      end
   endtask

   task automatic test_back_to_back;
      launch(1'b0, 8'h70, 8'h30);
      finish(1'b0, 8'hA0, 1'b0, 8, 1'b1, "b2b_first");
      start8 = 1'b1;
      a8 = 8'h80;
      b8 = 8'h80;
      @(posedge clk);
      @(negedge clk);
      start8 = 1'b0;
      checks++;
      if (u_dut8.state_q !== S_RUN || busy8 !== 1'b1 || done8 !== 1'b0) begin
         errors++;
         $display("FAIL b2b_no_bubble: got state=%0d busy=%b done=%b, expected RUN 1 0",
                  u_dut8.state_q, busy8, done8);
      end
      checks++;
      if (sum8 !== 8'hA0) begin
         errors++;
         $display("FAIL b2b_hold_prev: got %h, expected a0", sum8);
      end
      finish(1'b0, 8'h00, 1'b1, 8, 1'b0, "b2b_second");
   endtask

   task automatic test_reset_abort;
      launch(1'b0, 8'h1E, 8'h1E);
      finish(1'b0, 8'h3C, 1'b0, 8, 1'b0, "pre_abort");
      launch(1'b0, 8'hFF, 8'hFF);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if (busy8 !== 1'b0 || done8 !== 1'b0) begin
         errors++;
         $display("FAIL abort_ctrl: got busy=%b done=%b, expected 0 0", busy8, done8);
      end
      checks++;
      if (sum8 !== 8'h00 || co8 !== 1'b0) begin
         errors++;
         $display("FAIL abort_result: got %b_%h, expected 0_00", co8, sum8);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (done8 !== 1'b0 || busy8 !== 1'b0) begin
         errors++;
         $display("FAIL abort_no_done: got done=%b busy=%b, expected 0 0", done8, busy8);
      end
      launch(1'b0, 8'h01, 8'h02);
      finish(1'b0, 8'h03, 1'b0, 8, 1'b0, "after_abort");
   endtask

   task automatic test_width1;
      launch(1'b1, 8'd0, 8'd0);
      finish(1'b1, 8'd0, 1'b0, 1, 1'b0, "w1_0_0");
      launch(1'b1, 8'd1, 8'd0);
      finish(1'b1, 8'd1, 1'b0, 1, 1'b0, "w1_1_0");
      launch(1'b1, 8'd0, 8'd1);
      finish(1'b1, 8'd1, 1'b0, 1, 1'b0, "w1_0_1");
      launch(1'b1, 8'd1, 8'd1);
      finish(1'b1, 8'd0, 1'b1, 1, 1'b0, "w1_1_1");
   endtask

   initial begin
      checks = 0;
      errors = 0;
      start8 = 1'b0;
      a8     = '0;
      b8     = '0;
      start1 = 1'b0;
      a1     = '0;
      b1     = '0;
      test_reset();
      test_carry_overflow();
      test_patterns();
      test_start_ignored();
      test_back_to_back();
      test_reset_abort();
      test_width1();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
